// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: region-decoded MMIO interconnect with req/ready handshake and error responses.
// Optional ACCESS wait timeout enabled by defining MMIO_BUS_TIMEOUT_EN.
module mmio_bus_ctrl #(
  parameter int NUM_SLAVES  = 5,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_HI      = 31,
  parameter int SEL_LO      = 28,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         req,
  input  logic                         wmem,
  input  logic [2:0]                   memc,
  input  logic [ADDR_W-1:0]            A,
  input  logic [DATA_W-1:0]            Di,
  output logic                         ready,
  output logic [DATA_W-1:0]            Do,
  output logic                         err,
  output logic [7:0]                   err_cnt,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic                         s_wmem,
  output logic [2:0]                   s_memc,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ready
);
  localparam int SEL_W = SEL_HI - SEL_LO + 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic                  ready_q, ready_d, err_q, err_d, s_wmem_q, s_wmem_d;
  logic [DATA_W-1:0]     do_q, do_d, s_wdata_q, s_wdata_d, rdata;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic [NUM_SLAVES-1:0] s_sel_q, s_sel_d;
  logic [2:0]            s_memc_q, s_memc_d;
  logic [ADDR_W-1:0]     s_addr_q, s_addr_d, addr;
  logic [SEL_W-1:0]      region;
  logic                  mapped, hit, timeout;
  always_comb begin
    region = A[SEL_HI:SEL_LO];
    mapped = int'(region) < NUM_SLAVES;
    addr = A;
    addr[SEL_HI:SEL_LO] = '0;
    hit = |(s_ready & s_sel_q);
    rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++)
      rdata = rdata | (s_rdata[k*DATA_W +: DATA_W] & {DATA_W{s_sel_q[k]}});
  end
`ifdef MMIO_BUS_TIMEOUT_EN
  localparam int CNT_W = TIMEOUT_CYC > 255 ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  // counter reads k-1 in the k-th ACCESS cycle, so the limit trips on cycle TIMEOUT_CYC
  assign wcnt_d  = state_q == ACCESS ? wcnt_q + CNT_W'(1) : '0;
  assign timeout = state_q == ACCESS && wcnt_q == CNT_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge CLK) wcnt_q <= RESET ? '0 : wcnt_d;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    ready_d   = 1'b0;
    do_d      = do_q;
    err_d     = err_q;
    s_sel_d   = s_sel_q;
    s_wmem_d  = s_wmem_q;
    s_memc_d  = s_memc_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    case (state_q)
      IDLE: if (req) begin
        s_memc_d  = memc;
        s_addr_d  = addr;
        s_wdata_d = Di;
        if (mapped) begin
          s_sel_d  = NUM_SLAVES'(1) << region;
          s_wmem_d = wmem;
          state_d  = ACCESS;
        end else begin
          do_d    = '0;
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = RESP;
        end
      end
      ACCESS: if (hit || timeout) begin
        do_d     = hit && !s_wmem_q ? rdata : '0;
        err_d    = !hit;
        s_sel_d  = '0;
        s_wmem_d = 1'b0;
        ready_d  = 1'b1;
        state_d  = RESP;
      end
      default: state_d = IDLE;
    endcase
    err_cnt_d = ready_d && err_d && err_cnt_q != 8'hFF ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      do_q      <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      s_sel_q   <= '0;
      s_wmem_q  <= 1'b0;
      s_memc_q  <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      do_q      <= do_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      s_sel_q   <= s_sel_d;
      s_wmem_q  <= s_wmem_d;
      s_memc_q  <= s_memc_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
    end
  end
  assign ready   = ready_q;
  assign Do      = do_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign s_sel   = s_sel_q;
  assign s_wmem  = s_wmem_q;
  assign s_memc  = s_memc_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb_mmio_bus_ctrl: table-driven directed checks of mmio_bus_ctrl plus reset, saturation and timeout sequences.
module tb_mmio_bus_ctrl;
  logic         clk = 0, rst = 1, req = 0, wmem = 0;
  logic [2:0]   memc = 0;
  logic [31:0]  a = 0, di = 0, dout, s_addr, s_wdata;
  logic         ready, err, s_wmem;
  logic [7:0]   err_cnt;
  logic [4:0]   s_sel, s_ready = 0;
  logic [2:0]   s_memc;
  logic [159:0] s_rdata = 0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mmio_bus_ctrl #(.TIMEOUT_CYC(8)) dut (
    .CLK(clk), .RESET(rst), .req(req), .wmem(wmem), .memc(memc), .A(a), .Di(di),
    .ready(ready), .Do(dout), .err(err), .err_cnt(err_cnt), .s_sel(s_sel), .s_wmem(s_wmem),
    .s_memc(s_memc), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready)
  );
  typedef struct {
    logic        wmem;
    logic [2:0]  memc;
    logic [31:0] a, di, rd;
    int          waits;
    logic [4:0]  sel;
    logic [31:0] addr, dout;
    logic        err;
    int          lat, wcyc;
    logic [7:0]  cnt;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    int n = 0, wc = 0;
    logic done = 0;
    @(negedge clk);
    chk("ready_low_idle", 32'(ready), 0);
    req = 1; wmem = v.wmem; memc = v.memc; a = v.a; di = v.di;
    for (int k = 0; k < 5; k++) s_rdata[k*32 +: 32] = v.sel[k] ? v.rd : 32'hBAD0_0000 | k;
    s_ready = ~v.sel;
    while (!done && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ready) done = 1;
      else begin
        if (n == 1) begin
          chk("s_sel", 32'(s_sel), 32'(v.sel));
          chk("s_addr", s_addr, v.addr);
          chk("s_wdata", s_wdata, v.di);
          chk("s_memc", 32'(s_memc), 32'(v.memc));
        end
        if (s_wmem) wc++;
        s_ready = ~v.sel | (n > v.waits ? v.sel : 5'b0);
      end
    end
    chk("latency", 32'(n), 32'(v.lat));
    chk("Do", dout, v.dout);
    chk("err", 32'(err), 32'(v.err));
    chk("err_cnt", 32'(err_cnt), 32'(v.cnt));
    chk("sel_dropped", 32'({s_sel, s_wmem}), 0);
    chk("wmem_cycles", 32'(wc), 32'(v.wcyc));
    req = 0; s_ready = 0;
  endtask
  initial begin
    vec_t v;
    int seen;
    vecs[0] = '{0, 3'd2, 32'h1000_0010, 32'h0, 32'hCAFE_0001, 0, 5'b00010, 32'h0000_0010, 32'hCAFE_0001, 0, 2, 0, 8'd0};
    vecs[1] = '{1, 3'd2, 32'h4000_0004, 32'h55, 32'h9999_9999, 3, 5'b10000, 32'h0000_0004, 32'h0, 0, 5, 4, 8'd0};
    vecs[2] = '{0, 3'd2, 32'h7000_0000, 32'h0, 32'h0, 0, 5'b00000, 32'h0, 32'h0, 1, 1, 0, 8'd1};
    vecs[3] = '{0, 3'd0, 32'h0000_0100, 32'h0, 32'h1111_0000, 1, 5'b00001, 32'h0000_0100, 32'h1111_0000, 0, 3, 0, 8'd1};
    vecs[4] = '{0, 3'd1, 32'h2ABC_DEF0, 32'h0, 32'h2222_2222, 0, 5'b00100, 32'h0ABC_DEF0, 32'h2222_2222, 0, 2, 0, 8'd1};
    vecs[5] = '{0, 3'd2, 32'hF000_0008, 32'h0, 32'h0, 0, 5'b00000, 32'h0, 32'h0, 1, 1, 0, 8'd2};
    vecs[6] = '{1, 3'd2, 32'h3000_0000, 32'hDEAD_BEEF, 32'h1234_5678, 0, 5'b01000, 32'h0, 32'h0, 0, 2, 1, 8'd2};
    vecs[7] = '{0, 3'd2, 32'h5000_0000, 32'h0, 32'h0, 0, 5'b00000, 32'h0, 32'h0, 1, 1, 0, 8'd3};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_outs", 32'({err, s_wmem, s_sel, s_memc}), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_Do", dout, 0);
    for (int i = 0; i < 8; i++) run(vecs[i]);
`ifdef MMIO_BUS_TIMEOUT_EN
    run('{0, 3'd2, 32'h1000_0000, 32'h0, 32'hABCD_0001, 99, 5'b00010, 32'h0, 32'h0, 1, 9, 0, 8'd4});
    run('{0, 3'd2, 32'h1000_0000, 32'h0, 32'hABCD_0001, 7, 5'b00010, 32'h0, 32'hABCD_0001, 0, 9, 0, 8'd4});
`endif
    @(negedge clk);
    req = 1; wmem = 1; a = 32'h1000_0020; di = 32'h77; s_ready = 0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_pre_sel", 32'({s_sel, s_wmem}), 32'({5'b00010, 1'b1}));
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0; req = 0;
    chk("abort_sel", 32'(s_sel), 0);
    chk("abort_wmem", 32'(s_wmem), 0);
    chk("abort_ready", 32'(ready), 0);
    chk("abort_err_cnt", 32'(err_cnt), 0);
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (ready || s_sel != 0) seen++;
    end
    chk("abort_quiet", 32'(seen), 0);
    v = vecs[0];
    run(v);
    @(negedge clk);
    req = 1; wmem = 0; a = 32'h7000_0000;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("err_cnt_50", 32'(err_cnt), 50);
    repeat (500) @(posedge clk);
    @(negedge clk);
    chk("err_cnt_sat", 32'(err_cnt), 255);
    req = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
